// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI register bridge.
//   - register address map
//   - frame length and bit-counter width
//   - FSM state encoding
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t SHIFT   = 2'd1;
    localparam state_t OVERRUN = 2'd2;
    localparam state_t DONE    = 2'd3;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI pin bundle.
//   sclk, copi, ncs : driven by the SPI controller (master)
//   cipo, cipo_oe   : driven by the bridge (slave)
interface spi_reg_bridge_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport slave  (input  sclk, copi, ncs, output cipo, cipo_oe);
    modport master (output sclk, copi, ncs, input  cipo, cipo_oe);
endinterface

// File: rtl/sync_edge_det.sv
// Pin synchronizer with edge detection.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input pin
//   level    : synchronized level (last synchronizer flop)
//   rise     : one-cycle pulse, STAGES+1 cycles after a pin rising edge
//   fall     : one-cycle pulse, STAGES+1 cycles after a pin falling edge
// All flops reset to RST_VAL so leaving reset never produces a false edge.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] ff;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff   <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            ff   <= {ff[STAGES-2:0], din};
            prev <= ff[STAGES-1];
            rise <= ff[STAGES-1] & ~prev;
            fall <= ~ff[STAGES-1] & prev;
        end
    end

    assign level = ff[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target holding the PWM control registers.
//   clk, rst          : system clock, async active-high reset
//   bus (slave)       : sclk/copi/ncs in, cipo/cipo_oe out
//   en_reg_out_*      : registers 0x00/0x01
//   en_reg_pwm_*      : registers 0x02/0x03
//   pwm_duty_cycle    : register 0x04
//   wr_strobe         : pulse on register commit (same cycle as the update)
//   frame_err         : pulse when a frame is discarded
// Frame: bit15 write flag, bits14:8 address, bits7:0 data, MSB first.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_reg_bridge_if.slave     bus,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output logic                wr_strobe,
    output logic                frame_err
);

    localparam int NUM_REGS = MAX_ADDR + 1;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;
    logic copi_s,   copi_rise, copi_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(bus.sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(bus.ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(bus.copi),
        .level(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, ncs_lvl, copi_rise, copi_fall};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      sr;
    logic             ovr;
    logic [7:0]       out_sr;
    logic             oe;
    logic [7:0]       regs [NUM_REGS];
    logic [7:0]       rd_data;
    logic             addr_ok;
    logic             is_write;
    logic             full_frame;

    // Read address is the low 7 bits of the shift register once 8 bits are in.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (sr[6:0] == 7'(i)) rd_data = regs[i];
    end

    assign addr_ok    = int'(sr[14:8]) <= MAX_ADDR;
    assign is_write   = sr[15];
    assign full_frame = (cnt == CNT_W'(FRAME_BITS)) && !ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            ovr       <= 1'b0;
            out_sr    <= '0;
            oe        <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    oe     <= 1'b0;
                    out_sr <= '0;
                    if (ncs_fall) begin
                        cnt   <= '0;
                        sr    <= '0;
                        ovr   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // ncs edge wins over a coincident sclk edge.
                    if (ncs_rise) begin
                        state  <= DONE;
                        oe     <= 1'b0;
                        out_sr <= '0;
                    end else if (sclk_rise) begin
                        if (cnt == CNT_W'(FRAME_BITS)) begin
                            state  <= OVERRUN;
                            ovr    <= 1'b1;
                            oe     <= 1'b0;
                            out_sr <= '0;
                        end else begin
                            sr  <= {sr[14:0], copi_s};
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        // First falling edge after the header of a read: load data.
                        if (!oe && cnt == CNT_W'(8) && !sr[7]) begin
                            oe     <= 1'b1;
                            out_sr <= rd_data;
                        end else if (oe) begin
                            out_sr <= {out_sr[6:0], 1'b0};
                        end
                    end
                end
                OVERRUN: begin
                    if (ncs_rise) state <= DONE;
                end
                DONE: begin
                    if (full_frame && is_write && addr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (sr[14:8] == 7'(i)) regs[i] <= sr[7:0];
                        wr_strobe <= 1'b1;
                    end else if (!full_frame || (is_write && !addr_ok)) begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cipo    = oe & out_sr[7];
    assign bus.cipo_oe = oe;

    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule
